// File: rtl/cordic_pkg.sv
// Shared constants and types for the vectoring CORDIC.
// Angles are Q3.29 radians; x/y datapath is widened to IW bits.
package cordic_pkg;

  localparam int DW   = 32;
  localparam int FRAC = 29;
  localparam int IW   = 34;
  localparam int CW   = 6;

  localparam logic signed [DW-1:0] PI_2 = 32'sh3243F6A9;
  localparam logic signed [DW-1:0] PI   = 32'sh6487ED51;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // round(atan(2^-i) * 2^29)
  localparam logic signed [DW-1:0] ATAN_TAB [32] = '{
    32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
    32'sd33510843,  32'sd16771758,  32'sd8387925,   32'sd4194219,
    32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
    32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384,
    32'sd8192,      32'sd4096,      32'sd2048,      32'sd1024,
    32'sd512,       32'sd256,       32'sd128,       32'sd64,
    32'sd32,        32'sd16,        32'sd8,         32'sd4,
    32'sd2,         32'sd1,         32'sd0,         32'sd0
  };

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring micro-rotation: steer y toward zero, track angle in z.
// Purely combinational; the top reuses it every RUN cycle.
module cordic_vec_stage
  import cordic_pkg::*;
(
  input  logic signed [IW-1:0] x_i,
  input  logic signed [IW-1:0] y_i,
  input  logic signed [DW-1:0] z_i,
  input  logic signed [DW-1:0] atan_i,
  input  logic        [4:0]    i_i,
  output logic signed [IW-1:0] x_o,
  output logic signed [IW-1:0] y_o,
  output logic signed [DW-1:0] z_o
);

  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] ys;

  assign xs = x_i >>> i_i;
  assign ys = y_i >>> i_i;

  // rotate clockwise when y is non-negative, else counter-clockwise
  always_comb begin
    if (!y_i[IW-1]) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: magnitude (gain kept) and atan2(y,x).
// One micro-rotation per cycle, result ITERS+1 edges after accept.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int ITERS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] mag_out,
  output logic [31:0] theta_out
);

  localparam logic [CW-1:0] LAST = CW'(ITERS);
  localparam logic signed [IW-1:0] MAXP = 34'sh07FFFFFFF;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [IW-1:0] x_q, x_d;
  logic signed [IW-1:0] y_q, y_d;
  logic signed [DW-1:0] z_q, z_d;
  logic zero_q, zero_d;
  logic [DW-1:0] mag_q, mag_d;
  logic [DW-1:0] th_q, th_d;

  logic signed [IW-1:0] xe, ye;
  logic signed [IW-1:0] sx, sy;
  logic signed [DW-1:0] sz;

  assign xe = IW'($signed(x_in));
  assign ye = IW'($signed(y_in));

  cordic_vec_stage u_stage (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .atan_i (ATAN_TAB[cnt_q[4:0]]),
    .i_i    (cnt_q[4:0]),
    .x_o    (sx),
    .y_o    (sy),
    .z_o    (sz)
  );

  // next state: pre-rotate on accept, iterate, then latch the result
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    th_d    = th_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          cnt_d   = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          if (!x_in[DW-1]) begin
            x_d = xe;
            y_d = ye;
            z_d = '0;
          end else if (!y_in[DW-1]) begin
            x_d = ye;
            y_d = -xe;
            z_d = PI_2;
          end else begin
            x_d = -ye;
            y_d = xe;
            z_d = -PI_2;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          if (zero_q) begin
            mag_d = '0;
            th_d  = '0;
          end else begin
            mag_d = (x_q > MAXP) ? 32'h7FFFFFFF : x_q[DW-1:0];
            th_d  = z_q;
          end
        end else begin
          x_d   = sx;
          y_d   = sy;
          z_d   = sz;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      th_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      th_q    <= th_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign mag_out   = mag_q;
  assign theta_out = th_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector.
// Reference: real-valued gain*|v| and atan2 scaled to Q3.29.
module tb_cordic_vector;

  localparam int ITERS = 30;
  localparam real SC = 536870912.0;
  localparam real PI_R = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic out_valid;
  logic out_ready;
  logic [31:0] mag_out;
  logic [31:0] theta_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_vector #(.ITERS(ITERS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .theta_out (theta_out)
  );

  function automatic real gain();
    real k = 1.0;
    real p = 1.0;
    for (int i = 0; i < ITERS; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    return k;
  endfunction

  function automatic longint ref_mag(input logic signed [31:0] x,
                                     input logic signed [31:0] y);
    real m;
    if (x == 0 && y == 0) return 0;
    m = gain() * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    if (m > 2147483647.0) return 64'd2147483647;
    return longint'(m);
  endfunction

  function automatic real ref_th(input logic signed [31:0] x,
                                 input logic signed [31:0] y);
    if (x == 0 && y == 0) return 0.0;
    return $atan2(real'(y), real'(x)) * SC;
  endfunction

  function automatic real mag_err(input logic [31:0] got,
                                  input longint exp);
    real d;
    d = real'(longint'($signed(got))) - real'(exp);
    return (d < 0.0) ? -d : d;
  endfunction

  // angle error with wrap at +/-pi
  function automatic real ang_err(input logic [31:0] got, input real exp);
    real d;
    real tp;
    tp = 2.0 * PI_R * SC;
    d = real'($signed(got)) - exp;
    if (d > tp / 2.0) d = d - tp;
    if (d < -tp / 2.0) d = d + tp;
    return (d < 0.0) ? -d : d;
  endfunction

  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    @(negedge clk);
    x_in = x;
    y_in = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    x_in = 32'h10000000;
    y_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got rdy=%b vld=%b want rdy=1 vld=0",
               in_ready, out_valid);
    end
    checks++;
    if (mag_out !== 32'h0 || theta_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_out got mag=%h th=%h want 0 0",
               mag_out, theta_out);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] vx [6];
    logic [31:0] vy [6];
    int tol [6];
    int lat;
    longint em;
    real et;
    vx = '{32'h10000000, 32'h08000000, 32'hF0000000,
           32'h00000000, 32'h00000000, 32'h7FFFFFFF};
    vy = '{32'h00000000, 32'h08000000, 32'h00000000,
           32'hF0000000, 32'h00000000, 32'h7FFFFFFF};
    tol = '{16, 16, 32, 32, 0, 32};
    for (int k = 0; k < 6; k++) begin
      do_op(vx[k], vy[k], lat);
      em = ref_mag(vx[k], vy[k]);
      et = ref_th(vx[k], vy[k]);
      checks++;
      if (lat != ITERS + 1) begin
        failures++;
        $display("FAIL dir%0d_lat got %0d want %0d", k, lat, ITERS + 1);
      end
      checks++;
      if (mag_err(mag_out, em) > real'(tol[k])) begin
        failures++;
        $display("FAIL dir%0d_mag got %0d want %0d", k,
                 $signed(mag_out), em);
      end
      checks++;
      if (ang_err(theta_out, et) > real'(tol[k])) begin
        failures++;
        $display("FAIL dir%0d_th got %0d want %0.1f", k,
                 $signed(theta_out), et);
      end
      ack();
    end
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [31:0] y;
    int lat;
    longint em;
    real et;
    for (int k = 0; k < 20; k++) begin
      x = $urandom_range(32'h08000000, 32'h40000000);
      y = $urandom_range(0, 32'h40000000);
      if ($urandom_range(0, 1) == 1) x = -x;
      if ($urandom_range(0, 1) == 1) y = -y;
      if ($urandom_range(0, 1) == 1) begin
        x = x ^ y;
        y = x ^ y;
        x = x ^ y;
      end
      do_op(x, y, lat);
      em = ref_mag(x, y);
      et = ref_th(x, y);
      checks++;
      if (lat != ITERS + 1) begin
        failures++;
        $display("FAIL rnd%0d_lat got %0d want %0d", k, lat, ITERS + 1);
      end
      checks++;
      if (mag_err(mag_out, em) > 128.0) begin
        failures++;
        $display("FAIL rnd%0d_mag x=%h y=%h got %0d want %0d", k, x, y,
                 $signed(mag_out), em);
      end
      checks++;
      if (ang_err(theta_out, et) > 256.0) begin
        failures++;
        $display("FAIL rnd%0d_th x=%h y=%h got %0d want %0.1f", k, x, y,
                 $signed(theta_out), et);
      end
      ack();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] m0;
    logic [31:0] t0;
    do_op(32'h0C000000, 32'h04000000, lat);
    m0 = mag_out;
    t0 = theta_out;
    checks++;
    if (lat != ITERS + 1) begin
      failures++;
      $display("FAIL bp_lat got %0d want %0d", lat, ITERS + 1);
    end
    @(negedge clk);
    in_valid = 1'b1;
    x_in = 32'h00000000;
    y_in = 32'h10000000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (mag_out !== m0 || theta_out !== t0 || in_ready !== 1'b0 ||
          out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d got mag=%h th=%h rdy=%b vld=%b want %h %h 0 1",
                 c, mag_out, theta_out, in_ready, out_valid, m0, t0);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_noacc got rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    do_op(32'h00000000, 32'h10000000, lat);
    checks++;
    if (ang_err(theta_out, ref_th(32'h0, 32'h10000000)) > 32.0) begin
      failures++;
      $display("FAIL bp_next_th got %0d want %0d", $signed(theta_out),
               32'sh3243F6A9);
    end
    ack();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    longint em;
    @(negedge clk);
    x_in = 32'h10000000;
    y_in = 32'h10000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || mag_out !== 32'h0 ||
        theta_out !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst got rdy=%b vld=%b mag=%h th=%h want 1 0 0 0",
               in_ready, out_valid, mag_out, theta_out);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(32'hF8000000, 32'h06000000, lat);
    em = ref_mag(32'hF8000000, 32'h06000000);
    checks++;
    if (lat != ITERS + 1) begin
      failures++;
      $display("FAIL post_rst_lat got %0d want %0d", lat, ITERS + 1);
    end
    checks++;
    if (mag_err(mag_out, em) > 32.0) begin
      failures++;
      $display("FAIL post_rst_mag got %0d want %0d", $signed(mag_out), em);
    end
    checks++;
    if (ang_err(theta_out, ref_th(32'hF8000000, 32'h06000000)) > 32.0) begin
      failures++;
      $display("FAIL post_rst_th got %0d want %0.1f", $signed(theta_out),
               ref_th(32'hF8000000, 32'h06000000));
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
